// File: rtl/chunked_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor that adds CHUNK bits per clock with a rippled carry register.
// Latency: accept edge, then N=WIDTH/CHUNK BUSY cycles; valid_o strobes in cycle N+1.
// Backpressure: ready_o low while BUSY; valid_i ignored then, requester holds valid_i until ready_o.
module chunked_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             carry_i,
  input  logic             sub_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o,
  output logic             overflow_o,
  output logic             valid_o
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  // Operands are kept as shift registers: the chunk being added is always
  // the low CHUNK bits, so no variable part-selects are needed.
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  // Working sum fills from the top; after N shifts it holds the full result.
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             valid_q, valid_d;

  logic [CHUNK-1:0] chunk_sum;
  logic             chunk_cout;

  // Ripple chain of CHUNK full-adder cells over the current low chunk.
  always_comb begin
    logic c;
    c         = carry_q;
    chunk_sum = '0;
    for (int i = 0; i < CHUNK; i++) begin
      chunk_sum[i] = a_q[i] ^ b_q[i] ^ c;
      c            = (a_q[i] & b_q[i]) | (c & (a_q[i] ^ b_q[i]));
    end
    chunk_cout = c;
  end

  // Next-state and datapath update for the IDLE/BUSY/DONE sequence.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    work_d  = work_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    valid_d = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (valid_i) begin
          a_d     = a_i;
          b_d     = sub_i ? ~b_i : b_i;
          carry_d = sub_i ? 1'b1 : carry_i;
          cnt_d   = '0;
          state_d = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        work_d                    = work_q >> CHUNK;
        work_d[WIDTH-1 -: CHUNK]  = chunk_sum;
        a_d                       = a_q >> CHUNK;
        b_d                       = b_q >> CHUNK;
        carry_d                   = chunk_cout;
        if (cnt_q == LAST) begin
          // On the last chunk the low bits of a_q/b_q are the operand MSBs.
          sum_d   = work_d;
          cout_d  = chunk_cout;
          ovf_d   = (a_q[CHUNK-1] == b_q[CHUNK-1]) && (chunk_sum[CHUNK-1] != a_q[CHUNK-1]);
          valid_d = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset taking priority over any accept.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      work_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      work_q  <= work_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  assign ready_o    = (state_q != BUSY);
  assign sum_o      = sum_q;
  assign carry_o    = cout_q;
  assign overflow_o = ovf_q;
  assign valid_o    = valid_q;

endmodule

// File: tb/tb_chunked_adder.sv
module tb_chunked_adder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance k: 0=(32,8) 1=(32,1) 2=(32,32) 3=(16,4) 4=(64,16)
  logic [63:0] a_s [5];
  logic [63:0] b_s [5];
  logic [4:0]  valid_v, cin_v, sub_v;
  wire  [4:0]  ready_v, vo_v, co_v, ov_v;
  wire  [31:0] sum0, sum1, sum2;
  wire  [15:0] sum3;
  wire  [63:0] sum4;

  int nvec = 0;
  int nerr = 0;

  chunked_adder #(.WIDTH(32), .CHUNK(8)) u0 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_v[0]), .ready_o(ready_v[0]),
    .a_i(a_s[0][31:0]), .b_i(b_s[0][31:0]), .carry_i(cin_v[0]), .sub_i(sub_v[0]),
    .sum_o(sum0), .carry_o(co_v[0]), .overflow_o(ov_v[0]), .valid_o(vo_v[0]));
  chunked_adder #(.WIDTH(32), .CHUNK(1)) u1 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_v[1]), .ready_o(ready_v[1]),
    .a_i(a_s[1][31:0]), .b_i(b_s[1][31:0]), .carry_i(cin_v[1]), .sub_i(sub_v[1]),
    .sum_o(sum1), .carry_o(co_v[1]), .overflow_o(ov_v[1]), .valid_o(vo_v[1]));
  chunked_adder #(.WIDTH(32), .CHUNK(32)) u2 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_v[2]), .ready_o(ready_v[2]),
    .a_i(a_s[2][31:0]), .b_i(b_s[2][31:0]), .carry_i(cin_v[2]), .sub_i(sub_v[2]),
    .sum_o(sum2), .carry_o(co_v[2]), .overflow_o(ov_v[2]), .valid_o(vo_v[2]));
  chunked_adder #(.WIDTH(16), .CHUNK(4)) u3 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_v[3]), .ready_o(ready_v[3]),
    .a_i(a_s[3][15:0]), .b_i(b_s[3][15:0]), .carry_i(cin_v[3]), .sub_i(sub_v[3]),
    .sum_o(sum3), .carry_o(co_v[3]), .overflow_o(ov_v[3]), .valid_o(vo_v[3]));
  chunked_adder #(.WIDTH(64), .CHUNK(16)) u4 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_v[4]), .ready_o(ready_v[4]),
    .a_i(a_s[4]), .b_i(b_s[4]), .carry_i(cin_v[4]), .sub_i(sub_v[4]),
    .sum_o(sum4), .carry_o(co_v[4]), .overflow_o(ov_v[4]), .valid_o(vo_v[4]));

  function automatic logic [63:0] sum_of(int k);
    case (k)
      0: return {32'd0, sum0};
      1: return {32'd0, sum1};
      2: return {32'd0, sum2};
      3: return {48'd0, sum3};
      default: return sum4;
    endcase
  endfunction

  function automatic int width_of(int k);
    case (k)
      3: return 16;
      4: return 64;
      default: return 32;
    endcase
  endfunction

  function automatic int n_of(int k);
    case (k)
      1: return 32;
      2: return 1;
      default: return 4;
    endcase
  endfunction

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      if (nerr <= 20) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic start(int k, logic [63:0] a, logic [63:0] b, logic cin, logic sub);
    a_s[k]     = a;
    b_s[k]     = b;
    cin_v[k]   = cin;
    sub_v[k]   = sub;
    valid_v[k] = 1'b1;
  endtask

  // Called at a negedge with a request presented; returns cycles from accept to strobe.
  task automatic await(int k, bit scramble, bit keep, output int lat, output int busy_low,
                       output logic [63:0] hold_sum);
    lat      = 999;
    busy_low = 0;
    hold_sum = '0;
    @(posedge clk);
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (vo_v[k]) begin
        lat = c;
        if (!keep) valid_v[k] = 1'b0;
        break;
      end
      if (c == 1) begin
        hold_sum   = sum_of(k);
        valid_v[k] = 1'b0;
      end
      if (!ready_v[k]) busy_low++;
      if (scramble) begin
        a_s[k]     = {$urandom, $urandom};
        b_s[k]     = {$urandom, $urandom};
        cin_v[k]   = 1'($urandom);
        sub_v[k]   = 1'($urandom);
        valid_v[k] = 1'b1;
      end
    end
  endtask

  task automatic run_op(int k, string tag, logic [63:0] a, logic [63:0] b, logic cin, logic sub,
                        logic [63:0] es, logic ec, logic eo, bit scramble,
                        output int busy_low, output logic [63:0] hold_sum);
    int lat;
    chk({tag, " rdy"}, 64'(ready_v[k]), 64'd1);
    start(k, a, b, cin, sub);
    await(k, scramble, 1'b0, lat, busy_low, hold_sum);
    chk({tag, " lat"}, 64'(lat), 64'(n_of(k) + 1));
    chk({tag, " sum"}, sum_of(k), es);
    chk({tag, " cout"}, 64'(co_v[k]), 64'(ec));
    chk({tag, " ovf"}, 64'(ov_v[k]), 64'(eo));
  endtask

  function automatic logic [63:0] pick(logic [63:0] mask, int w);
    case ($urandom_range(0, 5))
      0: return mask;
      1: return 64'd0;
      2: return 64'd1 << (w - 1);
      3: return mask >> 1;
      default: return {$urandom, $urandom} & mask;
    endcase
  endfunction

  task automatic sweep(int k);
    int          w, bl;
    logic [63:0] mask, a, b, bb, es, hs;
    logic [64:0] full;
    logic        cin, sub, ci, ec, eo;
    w    = width_of(k);
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    for (int i = 0; i < 1000; i++) begin
      a    = pick(mask, w);
      b    = pick(mask, w);
      cin  = 1'($urandom);
      sub  = 1'($urandom);
      bb   = sub ? (~b & mask) : b;
      ci   = sub ? 1'b1 : cin;
      full = {1'b0, a} + {1'b0, bb} + 65'(ci);
      es   = full[63:0] & mask;
      ec   = full[w];
      eo   = (a[w-1] == bb[w-1]) && (es[w-1] != a[w-1]);
      run_op(k, $sformatf("sweep k%0d", k), a, b, cin, sub, es, ec, eo, 1'(i), bl, hs);
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          bl, lat, strobes;
    logic [63:0] hs;
    rst     = 1'b1;
    valid_v = '0;
    cin_v   = '0;
    sub_v   = '0;
    for (int k = 0; k < 5; k++) begin
      a_s[k] = '0;
      b_s[k] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset rdy", 64'(ready_v[0]), 64'd1);
    chk("reset vld", 64'(vo_v[0]), 64'd0);
    chk("reset sum", sum_of(0), 64'd0);
    chk("reset cout", 64'(co_v[0]), 64'd0);
    chk("reset ovf", 64'(ov_v[0]), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op(0, "wrap", 64'hFFFFFFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0, bl, hs);
    chk("wrap busy", 64'(bl), 64'd4);
    run_op(0, "xchunk", 64'hFF, 64'h1, 1'b0, 1'b0, 64'h100, 1'b0, 1'b0, 1'b0, bl, hs);
    chk("xchunk hold", hs, 64'h0);
    run_op(0, "sovf", 64'h7FFFFFFF, 64'h1, 1'b0, 1'b0, 64'h80000000, 1'b0, 1'b1, 1'b0, bl, hs);
    chk("sovf hold", hs, 64'h100);
    run_op(0, "sub5m7", 64'h5, 64'h7, 1'b1, 1'b1, 64'hFFFFFFFE, 1'b0, 1'b0, 1'b1, bl, hs);
    run_op(0, "subovf", 64'h80000000, 64'h1, 1'b0, 1'b1, 64'h7FFFFFFF, 1'b1, 1'b1, 1'b1, bl, hs);
    run_op(0, "cin", 64'h12345678, 64'h11111111, 1'b1, 1'b0, 64'h2345678A, 1'b0, 1'b0, 1'b0, bl, hs);

    // Back-to-back: second request presented in the DONE cycle.
    start(0, 64'h0000FFFF, 64'h1, 1'b0, 1'b0);
    await(0, 1'b0, 1'b1, lat, bl, hs);
    chk("b2b first lat", 64'(lat), 64'd5);
    chk("b2b first sum", sum_of(0), 64'h10000);
    chk("b2b done rdy", 64'(ready_v[0]), 64'd1);
    start(0, 64'hFFFFFFFF, 64'hFFFFFFFF, 1'b0, 1'b0);
    await(0, 1'b1, 1'b0, lat, bl, hs);
    chk("b2b gap", 64'(lat), 64'd5);
    chk("b2b hold", hs, 64'h10000);
    chk("b2b sum", sum_of(0), 64'hFFFFFFFE);
    chk("b2b cout", 64'(co_v[0]), 64'd1);
    chk("b2b ovf", 64'(ov_v[0]), 64'd0);

    // Reset asserted during the third BUSY cycle abandons the operation.
    start(0, 64'h11111111, 64'h22222222, 1'b0, 1'b0);
    @(posedge clk);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      valid_v[0] = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    chk("midrst rdy", 64'(ready_v[0]), 64'd1);
    chk("midrst vld", 64'(vo_v[0]), 64'd0);
    chk("midrst sum", sum_of(0), 64'd0);
    chk("midrst cout", 64'(co_v[0]), 64'd0);
    rst = 1'b0;
    strobes = 0;
    repeat (10) begin
      @(negedge clk);
      if (vo_v[0]) strobes++;
    end
    chk("midrst strobes", 64'(strobes), 64'd0);
    run_op(0, "recover", 64'h1, 64'h2, 1'b0, 1'b0, 64'h3, 1'b0, 1'b0, 1'b0, bl, hs);

    fork
      sweep(0);
      sweep(1);
      sweep(2);
      sweep(3);
      sweep(4);
    join

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/chunked_adder.md
# chunked_adder

Parametrised multi-cycle adder/subtractor that adds two WIDTH-bit operands CHUNK bits per clock, rippling the carry between chunks through an internal carry register. It is the sequential successor of the team's 1-bit full adder, built as a ripple chain of CHUNK full-adder cells. It sits next to the ALU for wide operations where area is worth more than single-cycle latency. It uses a valid/ready request handshake and a one-cycle result strobe.

## Interface
- WIDTH, 32, operand/result width; must be a positive multiple of CHUNK.
- CHUNK, 8, bits added per cycle; 1 ≤ CHUNK ≤ WIDTH. N = WIDTH/CHUNK.
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- valid_i  in  1  request valid.
- ready_o  out  1  block can accept a request.
- a_i  in  WIDTH  operand A.
- b_i  in  WIDTH  operand B.
- carry_i  in  1  carry-in for add mode; ignored when sub_i=1.
- sub_i  in  1  0: A+B+carry_i; 1: A−B (computed as A+~B+1).
- sum_o  out  WIDTH  result, held stable between strobes.
- carry_o  out  1  carry out of the MSB; in sub mode 1 = no borrow.
- overflow_o  out  1  two's-complement signed overflow.
- valid_o  out  1  one-cycle strobe: result registers updated.

## Operation
- States: IDLE, BUSY, DONE.
- ready_o = 1 in IDLE and DONE, 0 in BUSY. It is a registered-state decode with no combinational path from valid_i.
- Accept occurs when valid_i && ready_o at a rising edge:
  - latch a_i;
  - latch b_i, or ~b_i when sub_i=1;
  - load the carry register with carry_i, or 1 when sub_i=1;
  - clear the chunk counter and go to BUSY.
- BUSY, chunk k (counter 0..N−1):
  - add bits [k·CHUNK +: CHUNK] of the latched A and B' plus the carry register;
  - write the CHUNK sum bits into the working sum register;
  - write the chunk carry-out into the carry register.
  - When k = N−1, go to DONE. Otherwise increment k.
- Entering DONE, the output registers are loaded together:
  - sum_o = working sum;
  - carry_o = final carry;
  - overflow_o = (A[MSB] == B'[MSB]) && (sum[MSB] != A[MSB]).
- DONE:
  - valid_o = 1 for exactly this one cycle.
  - If a request is accepted here, go to BUSY (back-to-back). Otherwise go to IDLE.
- valid_i in BUSY is ignored. The requester keeps valid_i high until it sees ready_o.
- Arithmetic is modulo 2^WIDTH. The result is identical to a single-cycle WIDTH-bit adder for all inputs.
- CHUNK = WIDTH: N = 1, one BUSY cycle.

## Timing
- Reset, at the first rising edge with rst_i=1:
  - state IDLE, counter 0;
  - sum_o = 0, carry_o = 0, overflow_o = 0, valid_o = 0, ready_o = 1 (visible the cycle after that edge);
  - internal operand and carry registers cleared.
- Reset while BUSY or DONE: the operation is abandoned, no valid_o is produced, and the outputs show the reset values.
- Reset has priority over a simultaneous accept.
- Latency: accept at edge 0 → BUSY during cycles 1..N → valid_o high in cycle N+1. sum_o, carry_o and overflow_o change only at the edge that starts the DONE cycle.
- Throughput: one result every N+1 cycles with back-to-back requests.
- Output registers hold their value through IDLE and through the following BUSY period until the next DONE.

## Test plan
- WIDTH=32, CHUNK=8: a=0xFFFFFFFF, b=0x00000001, carry_i=0, sub_i=0 → after 5 cycles valid_o pulses, sum_o=0x00000000, carry_o=1, overflow_o=0. ready_o is low during cycles 1..4.
- Cross-chunk carry: a=0x000000FF, b=0x00000001 → sum_o=0x00000100, carry_o=0. Also a=0x7FFFFFFF, b=1 → sum_o=0x80000000, overflow_o=1.
- Subtract: a=5, b=7, sub_i=1, carry_i=1 (ignored) → sum_o=0xFFFFFFFE, carry_o=0, overflow_o=0. Also a=0x80000000, b=1, sub_i=1 → sum_o=0x7FFFFFFF, overflow_o=1, carry_o=1.
- Back-to-back: valid_i held high with a new operand pair presented in the DONE cycle → second accept in DONE, second valid_o exactly 5 cycles after the first. Operand changes and valid_i during BUSY do not disturb the result.
- Reset mid-op: rst_i=1 during the third BUSY cycle → the next cycle has ready_o=1, valid_o=0, sum_o=0, and no strobe appears afterward.
- Parameter sweep with random operands (≥1000 per config), checking sum, carry and overflow against a single-cycle reference and latency = N+1:
  - (WIDTH, CHUNK) = (32,1), (32,32), (16,4), (64,16);
  - carry_i=1 add cases included.
